// File: rtl/alu_pkg.sv
// Shared encodings for the two-stage shifter/ALU execute unit.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_RSB  = 4'd4;
    localparam logic [3:0] OP_RSC  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_ORR  = 4'd7;
    localparam logic [3:0] OP_EOR  = 4'd8;
    localparam logic [3:0] OP_MOVA = 4'd9;
    localparam logic [3:0] OP_MOV  = 4'd10;
    localparam logic [3:0] OP_MVN  = 4'd11;
    localparam logic [3:0] OP_BIC  = 4'd12;

    localparam logic [1:0] AM_ROT_IMM   = 2'b00;
    localparam logic [1:0] AM_REG       = 2'b01;
    localparam logic [1:0] AM_ZEXT_IMM  = 2'b10;
    localparam logic [1:0] AM_SHIFT_REG = 2'b11;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic [1:0] {
        CC_KEEP = 2'd0,
        CC_ZERO = 2'd1,
        CC_ONE  = 2'd2
    } carry_code_e;

    function automatic carry_code_e cc_lit(input logic b);
        return b ? CC_ONE : CC_ZERO;
    endfunction

    function automatic bit data_w_legal(input int unsigned w);
        return (w >= 8) && (w <= 64) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/barrel_shift_unit.sv
// Stage-1 operand shifter: produces operand B and a deferred carry code.
// ALU_SHIFT_RRX_EN turns shifted-register ROR #0 into RRX.
module barrel_shift_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic [1:0]        am_i,
    input  logic [11:0]       imm_i,
    input  logic [DATA_W-1:0] rm_i,
    output logic [DATA_W-1:0] value_o,
    output carry_code_e       carry_o,
    output logic              ins_c_o
);

    logic [SHAMT_W-1:0]  amt;
    logic [1:0]          sh_type;
    logic [DATA_W-1:0]   imm8;
    logic [5:0]          rot_imm;
    logic [5:0]          rot_reg;
    logic [2*DATA_W-1:0] rot_imm_full;
    logic [2*DATA_W-1:0] rot_reg_full;
    logic [DATA_W:0]     lsl_ext;
    logic [DATA_W:0]     lsr_ext;
    logic [DATA_W:0]     asr_ext;

    assign amt     = imm_i[7 +: SHAMT_W];
    assign sh_type = imm_i[6:5];
    assign imm8    = DATA_W'(imm_i[7:0]);
    assign rot_imm = {1'b0, imm_i[11:8], 1'b0} & 6'(DATA_W - 1);
    assign rot_reg = 6'(amt) & 6'(DATA_W - 1);

    assign rot_imm_full = {imm8, imm8} >> rot_imm;
    assign rot_reg_full = {rm_i, rm_i} >> rot_reg;

    // One guard bit carries the last bit shifted out, covering amt >= DATA_W too.
    assign lsl_ext = {1'b0, rm_i} << amt;
    assign lsr_ext = {rm_i, 1'b0} >> amt;
    assign asr_ext = $signed({rm_i, 1'b0}) >>> amt;

    always_comb begin
        value_o = rm_i;
        carry_o = CC_KEEP;
        ins_c_o = 1'b0;
        case (am_i)
            AM_ROT_IMM: begin
                value_o = rot_imm_full[DATA_W-1:0];
                if (rot_imm != '0) carry_o = cc_lit(rot_imm_full[DATA_W-1]);
            end
            AM_REG:      value_o = rm_i;
            AM_ZEXT_IMM: value_o = DATA_W'(imm_i);
            default: begin
                if (amt != '0) begin
                    case (sh_type)
                        SH_LSL: begin
                            value_o = lsl_ext[DATA_W-1:0];
                            carry_o = cc_lit(lsl_ext[DATA_W]);
                        end
                        SH_LSR: begin
                            value_o = lsr_ext[DATA_W:1];
                            carry_o = cc_lit(lsr_ext[0]);
                        end
                        SH_ASR: begin
                            value_o = asr_ext[DATA_W:1];
                            carry_o = cc_lit(asr_ext[0]);
                        end
                        default: begin
                            value_o = rot_reg_full[DATA_W-1:0];
                            carry_o = cc_lit(rot_reg_full[DATA_W-1]);
                        end
                    endcase
                end
`ifdef ALU_SHIFT_RRX_EN
                else if (sh_type == SH_ROR) begin
                    value_o = rm_i >> 1;
                    carry_o = cc_lit(rm_i[0]);
                    ins_c_o = 1'b1;
                end
`endif
            end
        endcase
    end

endmodule

// File: rtl/alu_shift_pipe.sv
// Two-stage execute unit: registered barrel shifter, then ALU with N/Z/C/V flags.
// ALU_SHIFT_RRX_EN enables RRX for shifted-register ROR #0.
module alu_shift_pipe
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [1:0]        in_am,
    input  logic [11:0]       in_imm,
    input  logic [DATA_W-1:0] in_rn,
    input  logic [DATA_W-1:0] in_rm,
    input  logic              in_s,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v
);

    if (!data_w_legal(DATA_W)) begin : g_bad_width
        $error("alu_shift_pipe: DATA_W must be a power of two in 8..64");
    end

    logic [DATA_W-1:0] sh_value;
    carry_code_e       sh_cc;
    logic              sh_insc;

    logic              s1_valid_q, s1_valid_d;
    logic [3:0]        s1_op_q;
    logic              s1_s_q;
    logic [DATA_W-1:0] s1_a_q, s1_b_q;
    carry_code_e       s1_cc_q;
    logic              s1_insc_q;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q;
    logic              n_q, z_q, c_q, v_q;

    logic              s2_adv, in_fire;
    logic [DATA_W-1:0] b_eff, alu_x, alu_y, logic_res, result_d;
    logic [DATA_W:0]   sum;
    logic              alu_cin, is_arith, sh_carry;
    logic              n_d, z_d, c_d, v_d, flag_wr;

    barrel_shift_unit #(
        .DATA_W (DATA_W),
        .SHAMT_W(SHAMT_W)
    ) u_shift (
        .am_i   (in_am),
        .imm_i  (in_imm),
        .rm_i   (in_rm),
        .value_o(sh_value),
        .carry_o(sh_cc),
        .ins_c_o(sh_insc)
    );

    assign s2_adv      = !out_valid_q || out_ready;
    assign in_ready    = !s1_valid_q || s2_adv;
    assign in_fire     = in_valid && in_ready;
    assign s1_valid_d  = in_fire || (s1_valid_q && !s2_adv);
    assign out_valid_d = s2_adv ? s1_valid_q : out_valid_q;

    // Deferred carry/RRX resolution reads the live flag, so back-to-back S ops never stall.
    assign b_eff = s1_b_q | {c_q & s1_insc_q, {(DATA_W-1){1'b0}}};

    always_comb begin
        case (s1_cc_q)
            CC_ONE:  sh_carry = 1'b1;
            CC_ZERO: sh_carry = 1'b0;
            default: sh_carry = c_q;
        endcase

        alu_x    = s1_a_q;
        alu_y    = b_eff;
        alu_cin  = 1'b0;
        is_arith = 1'b1;
        case (s1_op_q)
            OP_ADD: alu_cin = 1'b0;
            OP_ADC: alu_cin = c_q;
            OP_SUB: begin alu_y = ~b_eff;  alu_cin = 1'b1; end
            OP_SBC: begin alu_y = ~b_eff;  alu_cin = c_q;  end
            OP_RSB: begin alu_x = b_eff; alu_y = ~s1_a_q; alu_cin = 1'b1; end
            OP_RSC: begin alu_x = b_eff; alu_y = ~s1_a_q; alu_cin = c_q;  end
            default: is_arith = 1'b0;
        endcase

        case (s1_op_q)
            OP_AND:  logic_res = s1_a_q & b_eff;
            OP_ORR:  logic_res = s1_a_q | b_eff;
            OP_EOR:  logic_res = s1_a_q ^ b_eff;
            OP_MOVA: logic_res = s1_a_q;
            OP_MOV:  logic_res = b_eff;
            OP_MVN:  logic_res = ~b_eff;
            OP_BIC:  logic_res = s1_a_q & ~b_eff;
            default: logic_res = '0;
        endcase

        sum      = {1'b0, alu_x} + {1'b0, alu_y} + {{DATA_W{1'b0}}, alu_cin};
        result_d = is_arith ? sum[DATA_W-1:0] : logic_res;
        n_d      = result_d[DATA_W-1];
        z_d      = (result_d == '0);
        c_d      = is_arith ? sum[DATA_W] : sh_carry;
        v_d      = is_arith ? ((alu_x[DATA_W-1] == alu_y[DATA_W-1]) &&
                               (result_d[DATA_W-1] != alu_x[DATA_W-1])) : v_q;
        flag_wr  = s1_valid_q && s1_s_q && (s1_op_q <= OP_BIC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= '0;
            s1_s_q       <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_cc_q      <= CC_KEEP;
            s1_insc_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            n_q          <= 1'b0;
            z_q          <= 1'b0;
            c_q          <= 1'b0;
            v_q          <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (in_fire) begin
                s1_op_q   <= in_opcode;
                s1_s_q    <= in_s;
                s1_a_q    <= in_rn;
                s1_b_q    <= sh_value;
                s1_cc_q   <= sh_cc;
                s1_insc_q <= sh_insc;
            end
            if (s2_adv && s1_valid_q) out_result_q <= result_d;
            if (s2_adv && flag_wr) begin
                n_q <= n_d;
                z_q <= z_d;
                c_q <= c_d;
                v_q <= v_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign flag_n     = n_q;
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign flag_v     = v_q;

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Directed + randomized bench for alu_shift_pipe (DATA_W=32) against a sequential reference model.
module tb_alu_shift_pipe;

    localparam logic [3:0] ADD = 4'd0, ADC = 4'd1, SUB = 4'd2, MOV = 4'd10;

    typedef struct {
        logic [31:0] r;
        logic        n, z, c, v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_s, out_valid, out_ready;
    logic [3:0]  in_opcode;
    logic [1:0]  in_am;
    logic [11:0] in_imm;
    logic [31:0] in_rn, in_rm, out_result;
    logic        flag_n, flag_z, flag_c, flag_v;

    int unsigned checks = 0, errors = 0, fire_cnt = 0;
    bit          rand_ready = 1'b0;
    bit          m_n, m_z, m_c, m_v;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    alu_shift_pipe #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_am(in_am), .in_imm(in_imm),
        .in_rn(in_rn), .in_rm(in_rm), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [31:0] x);
        return longint'($signed(x));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        logic [31:0] t = x;
        repeat (n) t = {t[0], t[31:1]};
        return t;
    endfunction

    function automatic void ref_shift(input logic [1:0] am, input logic [11:0] imm,
                                      input logic [31:0] rm, input bit c,
                                      output logic [31:0] v, output bit co);
        int unsigned amt = int'(imm[11:7]);
        int unsigned typ = int'(imm[6:5]);
        int unsigned r;
        v  = rm;
        co = c;
        case (am)
            2'd0: begin
                r = 2 * int'(imm[11:8]);
                v = rotr({24'd0, imm[7:0]}, r);
                if (r != 0) co = v[31];
            end
            2'd1: v = rm;
            2'd2: v = {20'd0, imm};
            default: begin
                if (amt == 0) begin
`ifdef ALU_SHIFT_RRX_EN
                    if (typ == 3) begin v = {c, rm[31:1]}; co = rm[0]; end
`endif
                end else if (typ == 0) begin
                    v = rm << amt;  co = rm[32 - amt];
                end else if (typ == 1) begin
                    v = rm >> amt;  co = rm[amt - 1];
                end else if (typ == 2) begin
                    v = $signed(rm) >>> amt; co = rm[amt - 1];
                end else begin
                    v = rotr(rm, amt); co = v[31];
                end
            end
        endcase
    endfunction

    task automatic model(input logic [3:0] op, input logic [1:0] am, input logic [11:0] imm,
                         input logic [31:0] a, input logic [31:0] rm, input bit s);
        logic [31:0]     b, res;
        bit              sc, nc, nv, borrow;
        longint unsigned A, B, r;
        longint          sr;
        exp_t            e;
        ref_shift(am, imm, rm, m_c, b, sc);
        A = a; B = b; borrow = !m_c;
        nc = m_c; nv = m_v; r = 0; sr = 0;
        case (op)
            4'd0: begin r = A + B;        sr = sx(a) + sx(b);         nc = r >= 64'h1_0000_0000; end
            4'd1: begin r = A + B + m_c;  sr = sx(a) + sx(b) + m_c;   nc = r >= 64'h1_0000_0000; end
            4'd2: begin r = A - B;        sr = sx(a) - sx(b);          nc = A >= B; end
            4'd3: begin r = A - B - borrow; sr = sx(a) - sx(b) - borrow; nc = A >= B + borrow; end
            4'd4: begin r = B - A;        sr = sx(b) - sx(a);          nc = B >= A; end
            4'd5: begin r = B - A - borrow; sr = sx(b) - sx(a) - borrow; nc = B >= A + borrow; end
            4'd6:  r = A & B;
            4'd7:  r = A | B;
            4'd8:  r = A ^ B;
            4'd9:  r = A;
            4'd10: r = B;
            4'd11: r = ~B;
            4'd12: r = A & ~B;
            default: r = 0;
        endcase
        res = r[31:0];
        if (op <= 4'd5) nv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        else if (op <= 4'd12) nc = sc;
        if (s && op <= 4'd12) begin
            m_n = res[31]; m_z = (res == 0); m_c = nc; m_v = nv;
        end
        e.r = res; e.n = m_n; e.z = m_z; e.c = m_c; e.v = m_v;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (out_valid) begin
            if (exp_q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
            else begin
                e = exp_q[0];
                chk("result", 64'(out_result), 64'(e.r));
                chk("flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'({e.n, e.z, e.c, e.v}));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            model(in_opcode, in_am, in_imm, in_rn, in_rm, in_s);
            fire_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] am, input logic [11:0] imm,
                         input logic [31:0] rn, input logic [31:0] rm, input logic s);
        int unsigned f0 = fire_cnt;
        int unsigned n  = 0;
        in_valid = 1'b1; in_opcode = op; in_am = am; in_imm = imm;
        in_rn = rn; in_rm = rm; in_s = s;
        while (fire_cnt == f0 && n < 50) begin tick(); n++; end
        if (fire_cnt == f0) chk("issue_timeout", 64'(fire_cnt - f0), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned f0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_s = 1'b0;
        in_opcode = '0; in_am = '0; in_imm = '0; in_rn = '0; in_rm = '0;
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(out_result), 64'd0);
        chk("reset_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        issue(ADD, 2'b01, 12'h000, 32'hFFFF_FFFF, 32'd1, 1'b1);
        drain();
        chk("add_wrap_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0110);

        issue(ADD, 2'b01, 12'h000, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(ADC, 2'b01, 12'h000, 32'd5, 32'd5, 1'b0);
        drain();
        chk("adc_noflag_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0110);

        issue(MOV, 2'b00, 12'h40C, 32'd0, 32'd0, 1'b1);
        drain();
        chk("rot_imm_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0000);

        issue(MOV, 2'b11, 12'h0C0, 32'd0, 32'h8400_0001, 1'b1);
        issue(MOV, 2'b11, 12'h260, 32'd0, 32'h0000_000F, 1'b1);
        drain();
        chk("ror4_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b1010);

        issue(SUB, 2'b01, 12'h000, 32'd3, 32'd5, 1'b1);
        drain();
        chk("sub_neg_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b1000);
        issue(SUB, 2'b01, 12'h000, 32'h8000_0000, 32'd1, 1'b1);
        drain();
        chk("sub_ovf_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0011);

        issue(4'd13, 2'b01, 12'h000, 32'd7, 32'd9, 1'b1);
        drain();
        chk("op13_flags_kept", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0011);

        issue(MOV, 2'b11, 12'h060, 32'd0, 32'h0000_0003, 1'b1);
        drain();

        out_ready = 1'b0;
        f0 = fire_cnt;
        issue(ADD, 2'b01, 12'h000, 32'd10, 32'd20, 1'b1);
        issue(SUB, 2'b01, 12'h000, 32'd1, 32'd2, 1'b1);
        in_valid = 1'b1; in_opcode = 4'd8; in_am = 2'b10; in_imm = 12'hABC;
        in_rn = 32'h1234_5678; in_rm = '0; in_s = 1'b1;
        repeat (5) tick();
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_accepts", 64'(fire_cnt - f0), 64'd2);
        out_ready = 1'b1;
        issue(4'd8, 2'b10, 12'hABC, 32'h1234_5678, 32'd0, 1'b1);
        drain();

        out_ready = 1'b0;
        issue(SUB, 2'b01, 12'h000, 32'd3, 32'd5, 1'b1);
        issue(ADD, 2'b01, 12'h000, 32'd1, 32'd1, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
        @(negedge clk);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'd0);
        chk("midreset_result", 64'(out_result), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        rand_ready = 1'b1;
        repeat (300) begin
            issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  12'($urandom_range(0, 4095)), rnd_word(), rnd_word(),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) tick();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_shift_pipe.md
Name: alu_shift_pipe

Overview:
Parametrised two-stage execute unit for the datapath.
- Stage 1 is a barrel-shifter operand stage; stage 2 is the ALU.
- Holds the N/Z/C/V flag register internally and updates it under an S bit; ADC/SBC/RSC read the stored C flag.
- Valid/ready handshake on both sides; sits between register-file read and writeback.

Parameters:
DATA_W, 32, datapath width; power of two, 8..64.
SHAMT_W, 5, width of register-shift amount field (I[11:7]); fixed.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
in_valid  in  1  request valid.
in_ready  out  1  stage 1 can accept.
in_opcode  in  4  ALU op.
in_am  in  2  addressing mode: 00 rotated imm, 01 Rm, 10 zero-extended I, 11 shifted Rm.
in_imm  in  12  I field.
in_rn  in  DATA_W  OperandA.
in_rm  in  DATA_W  Rm.
in_s  in  1  update flags.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts.
out_result  out  DATA_W  result.
flag_n, flag_z, flag_c, flag_v  out  1 each  flag register.

Behaviour:
Reset:
- Both stages empty; out_valid=0; out_result=0; all flags 0.
- Reset mid-transaction discards both stages.

Handshake:
- Stage 2 advances when !out_valid or out_ready.
- in_ready = !s1_valid or stage-2 advance (combinational; no bubble).
- Latency: 2 cycles from input fire to out_valid.
- Throughput: 1/cycle.
- out_result is held stable while out_valid && !out_ready.

Stage 1 (shifter), registered:
- AM 00: value = ROR(zero-ext I[7:0], (2*I[11:8]) mod DATA_W). If the rotate amount is 0, carry = keep-C; else carry = value[DATA_W-1].
- AM 01: value = Rm; carry = keep-C.
- AM 10: value = zero-ext I; carry = keep-C.
- AM 11: amt = I[11:7]; type = I[6:5].
  - LSL: amt 0 gives keep-C. 0<amt<DATA_W gives carry = Rm[DATA_W-amt]. amt>=DATA_W gives value 0; carry = Rm[0] if amt==DATA_W, else 0.
  - LSR: amt 0 gives value = Rm, keep-C. amt>=DATA_W gives 0; carry = Rm[DATA_W-1] if amt==DATA_W, else 0.
  - ASR: amt>=DATA_W gives sign fill; carry = sign.
  - ROR: amount = amt mod DATA_W; carry = value MSB unless amt==0, in which case keep-C.
- Carry is stored as a 2-bit code: keep-C / literal 0 / literal 1.
- Resolution against the flag register happens in stage 2, so back-to-back flag updates need no stall.

Stage 2 (ALU):
- Computes on the stage1→stage2 edge. Flags update at that same edge when in_s=1 and the op is valid.
- Arithmetic uses DATA_W+1-bit sums. C = carry-out for ADD/ADC; C = NOT borrow for SUB/SBC/RSB/RSC.
- Opcodes:
  - 0 ADD
  - 1 ADC: A+B+C
  - 2 SUB
  - 3 SBC: A-B-!C
  - 4 RSB
  - 5 RSC: B-A-!C
  - 6 AND, 7 ORR, 8 EOR
  - 9 MOVA: A
  - 10 MOV: B
  - 11 MVN
  - 12 BIC
- V for add: sign(A)==sign(B) && sign(R)!=sign(A). V for sub: sign(A)!=sign(B) && sign(R)!=sign(A); operands are swapped for RSB/RSC.
- Logical ops (6..12): C = resolved shifter carry; V unchanged.
- Opcodes 13-15: result 0, flags never written.
- N = R[DATA_W-1]; Z = (R==0).
- An op arriving in stage 2 sees the flags written by its predecessor, even if that predecessor is still stalled at the output.

Optional Feature:
ALU_SHIFT_RRX_EN:
- Defined: AM 11, ROR with amt 0 is RRX. value = {C, Rm[DATA_W-1:1]}, carry = literal Rm[0]. Stage 1 stores Rm>>1 plus an insert-C marker; stage 2 ORs the current C into the MSB.
- Undefined: ROR #0 passes Rm with keep-C.

Decomposition:
- Package alu_pkg: opcode localparams, AM encodings, shift-type encodings, carry-code enum, DATA_W legality check function.
- Sub-module barrel_shift_unit (stage-1 combinational shifter + carry code), instantiated once.

Test Plan:
- Reset then stream ADD (S=1), A=0xFFFFFFFF, AM01 Rm=1 → result 0 after 2 cycles; Z=1, C=1, N=0, V=0.
- Back-to-back: ADD S=1 (0xFFFFFFFF+1), then ADC S=0 A=5, Rm=5 → second result 11; flags stay Z=1, C=1.
- AM00 I=0x40C (0x0C ROR 8) → 0x0C000000. MOV S=1 → carry 0, N=0; C set by stage-2 flag rules.
- AM11 LSR #32 encoding impossible; instead ASR #1 on 0x84000001 → 0xC2000000, C=1. ROR #4 on 0x0000000F → 0xF0000000, C=1.
- SUB S=1, A=3, B=5 → 0xFFFFFFFE, C=0, N=1, V=0. SUB 0x80000000-1 → 0x7FFFFFFF, V=1, C=1.
- Hold out_ready=0 for 5 cycles with 3 ops issued → in_ready drops after 2 accepted; results emerge in order, unchanged. Assert reset mid-stall → out_valid=0 next cycle, flags 0.
